// File: rtl/fmul_sched.sv
// Round-robin scheduler sharing one pipelined fmul between N_REQ requesters; tags ride alongside the multiplier.
// Optional performance counters (perf_issue, perf_stall) are built when FMUL_SCHED_PERF_EN is defined.
module fmul_sched #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned LAT   = 3,
   parameter int unsigned IDW   = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 hold,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [32*N_REQ-1:0]  req_a,
   input  logic [32*N_REQ-1:0]  req_b,
   output logic [N_REQ-1:0]     req_ready,
   output logic [31:0]          mul_a,
   output logic [31:0]          mul_b,
   input  logic [31:0]          mul_s,
   output logic                 resp_valid,
   output logic [IDW-1:0]       resp_id,
   output logic [31:0]          resp_data,
   output logic                 idle
`ifdef FMUL_SCHED_PERF_EN
   ,
   output logic [31:0]          perf_issue,
   output logic [31:0]          perf_stall
`endif
);

   logic [IDW-1:0]     r_rr_ptr;
   logic [31:0]        r_mul_a;
   logic [31:0]        r_mul_b;
   logic [LAT:0]       r_tag_v;
   logic [IDW-1:0]     r_tag_id [LAT+1];

   logic [2*N_REQ-1:0] w_rot;
   logic [N_REQ-1:0]   w_grant;
   logic               w_xfer;
   logic [IDW-1:0]     w_gnt_id;
   logic [31:0]        w_gnt_a;
   logic [31:0]        w_gnt_b;

   // Rotating the doubled request vector puts rr_ptr at bit 0, so the scan is a plain first-one search.
   always_comb begin
      w_rot    = {req_valid, req_valid} >> r_rr_ptr;
      w_xfer   = 1'b0;
      w_gnt_id = '0;
      w_grant  = '0;
      w_gnt_a  = '0;
      w_gnt_b  = '0;
      if (!hold && !reset) begin
         for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!w_xfer && w_rot[k]) begin
               w_xfer   = 1'b1;
               w_gnt_id = IDW'((32'(r_rr_ptr) + k) % N_REQ);
            end
         end
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (w_xfer && (w_gnt_id == IDW'(i))) begin
            w_grant[i] = 1'b1;
            w_gnt_a    = req_a[32*i +: 32];
            w_gnt_b    = req_b[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr <= '0;
         r_mul_a  <= '0;
         r_mul_b  <= '0;
      end else if (w_xfer) begin
         r_rr_ptr <= (w_gnt_id == IDW'(N_REQ-1)) ? '0 : w_gnt_id + 1'b1;
         r_mul_a  <= w_gnt_a;
         r_mul_b  <= w_gnt_b;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tag_v <= '0;
         for (int unsigned k = 0; k <= LAT; k++) begin
            r_tag_id[k] <= '0;
         end
      end else begin
         r_tag_v     <= {r_tag_v[LAT-1:0], w_xfer};
         r_tag_id[0] <= w_gnt_id;
         for (int unsigned k = 1; k <= LAT; k++) begin
            r_tag_id[k] <= r_tag_id[k-1];
         end
      end
   end

   assign req_ready  = w_grant;
   assign mul_a      = r_mul_a;
   assign mul_b      = r_mul_b;
   assign resp_valid = r_tag_v[LAT];
   assign resp_id    = r_tag_id[LAT];
   assign resp_data  = mul_s;
   assign idle       = ~|r_tag_v;

`ifdef FMUL_SCHED_PERF_EN
   logic [31:0] r_perf_issue;
   logic [31:0] r_perf_stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_issue <= '0;
         r_perf_stall <= '0;
      end else begin
         if (w_xfer) begin
            r_perf_issue <= r_perf_issue + 32'd1;
         end
         if (|req_valid && !w_xfer) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign perf_issue = r_perf_issue;
   assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_fmul_sched.sv
// Self-checking bench for fmul_sched: table-driven grant checks plus a response scoreboard.
// Includes a behavioural 3-stage multiplier stand-in driving mul_s.
module tb_fmul_sched;
   localparam int unsigned N_REQ = 2;
   localparam int unsigned LAT   = 3;
   localparam int unsigned IDW   = 3;

   localparam logic [31:0] TWO   = 32'h40000000;
   localparam logic [31:0] THREE = 32'h40400000;
   localparam logic [31:0] SIX   = 32'h40C00000;
   localparam logic [31:0] P15   = 32'h3FC00000;
   localparam logic [31:0] P225  = 32'h40100000;
   localparam logic [31:0] M1    = 32'hBF800000;
   localparam logic [31:0] M2    = 32'hC0000000;
   localparam logic [31:0] ZERO  = 32'h00000000;

   logic                clk = 1'b0;
   logic                reset;
   logic                hold;
   logic [N_REQ-1:0]    req_valid;
   logic [32*N_REQ-1:0] req_a;
   logic [32*N_REQ-1:0] req_b;
   logic [N_REQ-1:0]    req_ready;
   logic [31:0]         mul_a;
   logic [31:0]         mul_b;
   logic [31:0]         mul_s;
   logic                resp_valid;
   logic [IDW-1:0]      resp_id;
   logic [31:0]         resp_data;
   logic                idle;
`ifdef FMUL_SCHED_PERF_EN
   logic [31:0]         perf_issue;
   logic [31:0]         perf_stall;
`endif

   fmul_sched #(.N_REQ(N_REQ), .LAT(LAT), .IDW(IDW)) dut (
      .clk        (clk),
      .reset      (reset),
      .hold       (hold),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_s      (mul_s),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .idle       (idle)
`ifdef FMUL_SCHED_PERF_EN
      ,
      .perf_issue (perf_issue),
      .perf_stall (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   // Truncating single-precision multiply, adequate for normal operands and zeros.
   function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      int          e;
      logic [47:0] p;
      s = a[31] ^ b[31];
      if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) return {s, 8'(e + 1), p[46:24]};
      return {s, 8'(e), p[45:23]};
   endfunction

   logic [31:0] m1, m2, m3;
   always @(posedge clk) begin
      m1 <= fmul_model(mul_a, mul_b);
      m2 <= m1;
      m3 <= m2;
   end
   assign mul_s = m3;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [IDW-1:0] id;
      logic [31:0]    data;
      int unsigned    due;
   } exp_t;
   exp_t sbq[$];

   always @(negedge clk) begin : mon
      exp_t e;
      if (resp_valid) begin
         if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_resp: got id %0d data %h, expected no response (cycle %0d)",
                     resp_id, resp_data, cyc);
         end else begin
            e = sbq.pop_front();
            chk("resp_cycle", cyc, e.due);
            chk("resp_id", 32'(resp_id), 32'(e.id));
            chk("resp_data", resp_data, e.data);
         end
      end else if (sbq.size() != 0 && cyc >= sbq[0].due) begin
         n_chk++;
         n_fail++;
         $display("FAIL missing_resp: got no response, expected id %0d data %h at cycle %0d",
                  sbq[0].id, sbq[0].data, sbq[0].due);
         void'(sbq.pop_front());
      end
   end

   typedef struct {
      logic [1:0]  v;
      logic        h;
      logic [31:0] a0, b0, a1, b1;
      logic [1:0]  rdy;
      logic [31:0] d;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] v, input logic h,
                               input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] a1, input logic [31:0] b1,
                               input logic [1:0] rdy, input logic [31:0] d);
      vec_t t;
      t.v = v; t.h = h; t.a0 = a0; t.b0 = b0; t.a1 = a1; t.b1 = b1; t.rdy = rdy; t.d = d;
      return t;
   endfunction

   // Drives one cycle of stimulus from posedge+1; checks grant (and optionally idle) at the negedge.
   task automatic apply(input vec_t t, input bit push, input bit ci, input logic ei);
      exp_t e;
      req_valid = t.v;
      hold      = t.h;
      req_a     = {t.a1, t.a0};
      req_b     = {t.b1, t.b0};
      @(negedge clk);
      chk("req_ready", 32'(req_ready), 32'(t.rdy));
      if (ci) chk("idle", 32'(idle), 32'(ei));
      if (push && t.rdy != 2'b00) begin
         e.id   = t.rdy[1] ? IDW'(1) : IDW'(0);
         e.data = t.d;
         e.due  = cyc + LAT + 1;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tv [23];
   vec_t nop;

   initial begin
      nop   = mk(2'b00, 1'b0, ZERO, ZERO, ZERO, ZERO, 2'b00, ZERO);
      tv[0] = mk(2'b01, 1'b0, TWO, THREE, ZERO, ZERO, 2'b01, SIX);
      for (int i = 1; i <= 4; i++) tv[i] = nop;
      tv[5]  = mk(2'b10, 1'b0, ZERO, ZERO, M1, TWO, 2'b10, M2);
      tv[6]  = mk(2'b10, 1'b0, ZERO, ZERO, M1, TWO, 2'b10, M2);
      tv[7]  = mk(2'b11, 1'b0, P15, P15, M1, TWO, 2'b01, P225);
      tv[8]  = mk(2'b11, 1'b0, P15, P15, M1, TWO, 2'b10, M2);
      tv[9]  = mk(2'b11, 1'b0, P15, P15, M1, TWO, 2'b01, P225);
      tv[10] = mk(2'b11, 1'b0, P15, P15, M1, TWO, 2'b10, M2);
      for (int i = 11; i <= 13; i++) tv[i] = mk(2'b01, 1'b1, P15, P15, ZERO, ZERO, 2'b00, ZERO);
      tv[14] = mk(2'b01, 1'b0, P15, P15, ZERO, ZERO, 2'b01, P225);
      tv[15] = mk(2'b01, 1'b0, ZERO, TWO, ZERO, ZERO, 2'b01, ZERO);
      tv[16] = mk(2'b01, 1'b0, TWO, THREE, ZERO, ZERO, 2'b01, SIX);
      tv[17] = mk(2'b10, 1'b0, ZERO, ZERO, ZERO, TWO, 2'b10, ZERO);
      for (int i = 18; i <= 22; i++) tv[i] = nop;

      reset     = 1'b1;
      hold      = 1'b0;
      req_valid = 2'b11;
      req_a     = {M1, TWO};
      req_b     = {TWO, THREE};
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
      chk("rst_mul_a", mul_a, 32'd0);
      chk("rst_mul_b", mul_b, 32'd0);
`ifdef FMUL_SCHED_PERF_EN
      chk("rst_perf_issue", perf_issue, 32'd0);
      chk("rst_perf_stall", perf_stall, 32'd0);
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 23; i++) apply(tv[i], 1'b1, 1'b0, 1'b0);
      @(negedge clk);
`ifdef FMUL_SCHED_PERF_EN
      chk("perf_issue", perf_issue, 32'd11);
      chk("perf_stall", perf_stall, 32'd3);
`endif
      @(posedge clk);
      #1;

      // idle drops only once a tag is in flight and returns after the response drains
      apply(mk(2'b01, 1'b0, TWO, THREE, ZERO, ZERO, 2'b01, SIX), 1'b1, 1'b1, 1'b1);
      for (int k = 1; k <= 5; k++) apply(nop, 1'b1, 1'b1, (k <= 4) ? 1'b0 : 1'b1);

      // two ops in flight are killed by reset; the first post-reset cycle already grants req0
      apply(mk(2'b11, 1'b0, TWO, THREE, M1, TWO, 2'b10, M2), 1'b0, 1'b0, 1'b0);
      apply(mk(2'b11, 1'b0, TWO, THREE, M1, TWO, 2'b01, SIX), 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      apply(mk(2'b11, 1'b0, TWO, THREE, M1, TWO, 2'b00, ZERO), 1'b0, 1'b0, 1'b0);
      apply(mk(2'b11, 1'b0, TWO, THREE, M1, TWO, 2'b00, ZERO), 1'b0, 1'b1, 1'b1);
      reset = 1'b0;
      apply(mk(2'b11, 1'b0, TWO, THREE, M1, TWO, 2'b01, SIX), 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 6; k++) apply(nop, 1'b1, 1'b0, 1'b0);

      @(negedge clk);
      chk("end_idle", 32'(idle), 32'd1);
      chk("sb_empty", 32'(sbq.size()), 32'd0);
`ifdef FMUL_SCHED_PERF_EN
      chk("end_perf_issue", perf_issue, 32'd1);
      chk("end_perf_stall", perf_stall, 32'd0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
